// File: rtl/updi_uart_tx.sv
// UPDI transmit serializer: pops one byte per frame from the TX FIFO and sends it
// as an 8E2 frame on the single-wire line, releasing the pad between frames.
module updi_uart_tx #(
    parameter int UART_CLK_DIV = 1736,
    parameter int GAP_BITS     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_tx_fifo_data,
    output logic       uart_tx_fifo_rd_en,
    input  logic       uart_tx_fifo_empty,
    input  logic       tx_hold,
    output logic       updi_tx,
    output logic       updi_tx_oe,
    output logic       busy,
    output logic       frame_done
);

    localparam int GAP_CYC = GAP_BITS * UART_CLK_DIV;
    localparam int CNT_MAX = (GAP_CYC > UART_CLK_DIV) ? GAP_CYC : UART_CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(UART_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_LOAD   = 4'd2;
    localparam logic [3:0] S_START  = 4'd3;
    localparam logic [3:0] S_DATA   = 4'd4;
    localparam logic [3:0] S_PARITY = 4'd5;
    localparam logic [3:0] S_STOP1  = 4'd6;
    localparam logic [3:0] S_STOP2  = 4'd7;
    localparam logic [3:0] S_GAP    = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             oe_q, oe_d;
    logic             rd_en_q, rd_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    // Next-state, bit timing and shift register update.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_end = (cyc_q == CNT_ZERO);
        case (state_q)
            S_IDLE: begin
                if (!uart_tx_fifo_empty && !tx_hold) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = uart_tx_fifo_data;
                par_d   = ^uart_tx_fifo_data;
                cyc_d   = BIT_RELOAD;
                bit_d   = 3'd0;
                state_d = S_START;
            end
            S_START, S_PARITY, S_STOP1: begin
                if (bit_end) begin
                    cyc_d = BIT_RELOAD;
                    if (state_q == S_START) begin
                        state_d = S_DATA;
                    end else if (state_q == S_PARITY) begin
                        state_d = S_STOP1;
                    end else begin
                        state_d = S_STOP2;
                    end
                end else begin
                    cyc_d = cyc_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d   = BIT_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q - CNT_ONE;
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    if (GAP_BITS > 0) begin
                        cyc_d   = GAP_RELOAD;
                        state_d = S_GAP;
                    end else begin
                        cyc_d   = CNT_ZERO;
                        state_d = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = CNT_ZERO;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        rd_en_d = (state_d == S_FETCH);
        busy_d  = (state_d != S_IDLE);
        oe_d    = (state_d >= S_START) && (state_d <= S_STOP2);
        done_d  = (state_d == S_STOP2) && (cyc_d == CNT_ZERO);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State, counters and registered outputs; reset releases the line at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= CNT_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            oe_q    <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            oe_q    <= oe_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uart_tx_fifo_rd_en = rd_en_q;
    assign updi_tx            = tx_q;
    assign updi_tx_oe         = oe_q;
    assign busy               = busy_q;
    assign frame_done         = done_q;

endmodule

// File: tb/tb_updi_uart_tx.sv
// Directed bench for updi_uart_tx: DIV=4 with GAP_BITS=0 (dut0) and GAP_BITS=2 (dut2).
module tb_updi_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data0 = 8'h00, data2 = 8'h00;
    logic       rd0, rd2, empty0, empty2;
    logic       hold0 = 1'b0, hold2 = 1'b0;
    logic       tx0, tx2, oe0, oe2, busy0, busy2, fd0, fd2;
    logic [7:0] mem0 [16];
    logic [7:0] mem2 [16];
    int         wr0 = 0, wr2 = 0, pops0 = 0, pops2 = 0;
    int         checks = 0, errors = 0;
    logic       sel_m = 1'b0;
    logic       oe_m, tx_m, fd_m, busy_m;

    always #5 clk = ~clk;

    updi_uart_tx #(.UART_CLK_DIV(4), .GAP_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .uart_tx_fifo_data(data0), .uart_tx_fifo_rd_en(rd0),
        .uart_tx_fifo_empty(empty0), .tx_hold(hold0), .updi_tx(tx0), .updi_tx_oe(oe0),
        .busy(busy0), .frame_done(fd0)
    );

    updi_uart_tx #(.UART_CLK_DIV(4), .GAP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .uart_tx_fifo_data(data2), .uart_tx_fifo_rd_en(rd2),
        .uart_tx_fifo_empty(empty2), .tx_hold(hold2), .updi_tx(tx2), .updi_tx_oe(oe2),
        .busy(busy2), .frame_done(fd2)
    );

    assign empty0 = (wr0 == pops0);
    assign empty2 = (wr2 == pops2);
    assign oe_m   = sel_m ? oe2 : oe0;
    assign tx_m   = sel_m ? tx2 : tx0;
    assign fd_m   = sel_m ? fd2 : fd0;
    assign busy_m = sel_m ? busy2 : busy0;

    // FIFO models: read data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        if (rd0 === 1'b1) begin
            data0 <= mem0[pops0[3:0]];
            pops0 <= pops0 + 1;
        end
        if (rd2 === 1'b1) begin
            data2 <= mem2[pops2[3:0]];
            pops2 <= pops2 + 1;
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [7:0] b);
        mem0[wr0[3:0]] = b;
        wr0 = wr0 + 1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wr2[3:0]] = b;
        wr2 = wr2 + 1;
    endtask

    // Walks one dut0 frame cycle by cycle, starting at the cycle the request is seen.
    task automatic frame_check(input logic [7:0] b, input logic par, input bit hold_mid);
        logic [11:0] exp;
        int p;
        exp = {2'b11, par, b, 1'b0};
        p = pops0;
        step;
        chk("rd_en_fetch", rd0, 1);
        chk("busy_fetch", busy0, 1);
        step;
        chk("rd_en_load", rd0, 0);
        chk("oe_load", oe0, 0);
        step;
        for (int bi = 0; bi < 12; bi++) begin
            for (int c = 0; c < 4; c++) begin
                chk("tx_bit", tx0, exp[bi]);
                chk("oe_frame", oe0, 1);
                chk("frame_done", fd0, (bi == 11 && c == 3) ? 1 : 0);
                if (hold_mid && bi == 5 && c == 0) hold0 = 1'b1;
                step;
            end
        end
        chk("oe_after", oe0, 0);
        chk("tx_after", tx0, 1);
        chk("busy_after", busy0, 0);
        chk("fd_after", fd0, 0);
        chk("one_pop", pops0 - p, 1);
    endtask

    // Two queued frames: measures start-edge spacing, decodes both bytes, counts strobes.
    task automatic measure(input bit sel, input logic [7:0] b1, input logic [7:0] b2, input int spacing);
        int t1, t2, rises, fd, last, rel, p;
        logic prev;
        logic [7:0] rx1, rx2;
        sel_m = sel;
        t1 = -1; t2 = -1; rises = 0; fd = 0; last = 0; prev = 1'b0;
        rx1 = 8'h00; rx2 = 8'h00;
        p = sel ? pops2 : pops0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            step;
            if (oe_m && !prev) begin
                rises++;
                last = cyc;
                if (rises == 1) t1 = cyc;
                else if (rises == 2) t2 = cyc;
            end
            prev = oe_m;
            rel = cyc - last;
            if (oe_m && rel >= 6 && rel <= 34 && (rel % 4) == 2) begin
                if (rises == 1) rx1[(rel - 6) / 4] = tx_m;
                else rx2[(rel - 6) / 4] = tx_m;
            end
            if (fd_m) fd++;
            if (!oe_m) chk("tx_released", tx_m, 1);
            if (sel && rises == 1 && rel >= 48 && rel <= 55) begin
                chk("busy_gap", busy_m, 1);
                chk("oe_gap", oe_m, 0);
            end
        end
        chk("start_spacing", t2 - t1, spacing);
        chk("byte1", rx1, b1);
        chk("byte2", rx2, b2);
        chk("frame_done_count", fd, 2);
        chk("pop_count", (sel ? pops2 : pops0) - p, 2);
    endtask

    initial begin
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) step;
        chk("rst_tx", tx0, 1);
        chk("rst_oe", oe0, 0);
        chk("rst_rd_en", rd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_fd", fd0, 0);
        chk("rst_oe2", oe2, 0);
        rst = 1'b0;
        step;
        step;
        chk("idle_empty", busy0, 0);

        push0(8'h55);
        frame_check(8'h55, 1'b0, 1'b0);
        push0(8'h01);
        frame_check(8'h01, 1'b1, 1'b0);
        push0(8'hFF);
        frame_check(8'hFF, 1'b0, 1'b0);

        push0(8'hA5);
        push0(8'h3C);
        measure(1'b0, 8'hA5, 8'h3C, 51);
        push2(8'h96);
        push2(8'h0F);
        measure(1'b1, 8'h96, 8'h0F, 59);

        hold0 = 1'b1;
        push0(8'hC3);
        for (int i = 0; i < 100; i++) begin
            step;
            chk("hold_rd_en", rd0, 0);
            chk("hold_busy", busy0, 0);
            chk("hold_oe", oe0, 0);
        end
        hold0 = 1'b0;
        frame_check(8'hC3, 1'b0, 1'b1);
        hold0 = 1'b0;

        push0(8'h00);
        step;
        step;
        step;
        repeat (17) step;
        chk("pre_rst_tx", tx0, 0);
        chk("pre_rst_oe", oe0, 1);
        rst = 1'b1;
        #1;
        chk("midrst_tx", tx0, 1);
        chk("midrst_oe", oe0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_rd_en", rd0, 0);
        step;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step;
            chk("post_rst_busy", busy0, 0);
            chk("post_rst_oe", oe0, 0);
        end
        chk("post_rst_pops", pops0, wr0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
